// File: rtl/sink_a_put_alloc_pkg.sv
// ---------------------------------------------------------------------------
// sink_a_put_alloc_pkg : shared widths, opcodes and helpers | Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

`ifndef SINK_A_PUT_ALLOC_DEFINES
`define SINK_A_PUT_ALLOC_DEFINES
`define PUTLISTS     8
`define PUT_BITS     3
`define DATA_BITS    32
`define MASK_BITS    4
`define SOURCE_BITS  4
`define OP_BITS      3
`define SIZE_BITS    3
`define ADDRESS_BITS 16
`define OPC_PUT_FULL 3'd0
`define OPC_PUT_PART 3'd1
`define OPC_GET      3'd4
`endif

package sink_a_put_alloc_pkg;

  localparam int c_putlists     = `PUTLISTS;
  localparam int c_put_bits     = `PUT_BITS;
  localparam int c_data_bits    = `DATA_BITS;
  localparam int c_mask_bits    = `MASK_BITS;
  localparam int c_source_bits  = `SOURCE_BITS;
  localparam int c_op_bits      = `OP_BITS;
  localparam int c_size_bits    = `SIZE_BITS;
  localparam int c_address_bits = `ADDRESS_BITS;
  // Wide enough for the largest burst a size field can describe.
  localparam int c_cnt_bits     = 1 << `SIZE_BITS;

  localparam logic [`OP_BITS-1:0] c_opc_put_full = `OPC_PUT_FULL;
  localparam logic [`OP_BITS-1:0] c_opc_put_part = `OPC_PUT_PART;
  localparam logic [`OP_BITS-1:0] c_opc_get      = `OPC_GET;

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_BURST = 1'b1
  } state_t;

  function automatic logic [c_put_bits-1:0] one2bin(input logic [c_putlists-1:0] oh);
    logic [c_put_bits-1:0] bin;
    bin = '0;
    for (int i = 0; i < c_putlists; i++) begin
      if (oh[i]) bin = bin | c_put_bits'(i);
    end
    return bin;
  endfunction

  // Beats remaining after the first one: max(1, 2^size / beat_bytes) - 1.
  function automatic logic [c_cnt_bits-1:0] beats_minus1(input logic [c_size_bits-1:0] size,
                                                         input int beat_lg);
    if (int'(size) <= beat_lg) return '0;
    return c_cnt_bits'((1 << (int'(size) - beat_lg)) - 1);
  endfunction

endpackage

`default_nettype wire

// File: rtl/put_free_pe.sv
// ---------------------------------------------------------------------------
// put_free_pe : lowest-set-bit priority encoder for the put-list free vector | Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module put_free_pe
  import sink_a_put_alloc_pkg::*;
(
  input  logic [c_putlists-1:0] free_vec,
  output logic                  any_free,
  output logic [c_putlists-1:0] onehot,
  output logic [c_put_bits-1:0] index
);

  logic [c_putlists-1:0] w_onehot;

  // Two's-complement trick isolates the lowest set bit.
  assign w_onehot = free_vec & (-free_vec);
  assign onehot   = w_onehot;
  assign any_free = |free_vec;
  assign index    = one2bin(w_onehot);

endmodule

`default_nettype wire

// File: rtl/sink_a_put_alloc.sv
// ---------------------------------------------------------------------------
// sink_a_put_alloc : A-channel sink that allocates put lists and pushes data | Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module sink_a_put_alloc
  import sink_a_put_alloc_pkg::*;
#(
  parameter int                  BEAT_BYTES   = `DATA_BITS/8,
  parameter logic [`OP_BITS-1:0] PUT_OPC_FULL = `OPC_PUT_FULL,
  parameter logic [`OP_BITS-1:0] PUT_OPC_PART = `OPC_PUT_PART
)
(
  input  logic                     clk,
  input  logic                     rst_n,

  input  logic                     a_valid_i,
  output logic                     a_ready_o,
  input  logic [`OP_BITS-1:0]      a_opcode_i,
  input  logic [`SIZE_BITS-1:0]    a_size_i,
  input  logic [`SOURCE_BITS-1:0]  a_source_i,
  input  logic [`ADDRESS_BITS-1:0] a_address_i,
  input  logic [`DATA_BITS-1:0]    a_data_i,
  input  logic [`MASK_BITS-1:0]    a_mask_i,

  output logic                     push_valid_o,
  input  logic                     push_ready_i,
  output logic [`PUT_BITS-1:0]     push_index_o,
  output logic [`DATA_BITS-1:0]    push_data_o,
  output logic [`MASK_BITS-1:0]    push_mask_o,

  output logic                     req_valid_o,
  input  logic                     req_ready_i,
  output logic [`OP_BITS-1:0]      req_opcode_o,
  output logic [`SIZE_BITS-1:0]    req_size_o,
  output logic [`SOURCE_BITS-1:0]  req_source_o,
  output logic [`ADDRESS_BITS-1:0] req_address_o,
  output logic [`PUT_BITS-1:0]     req_put_o,

  input  logic                     free_valid_i,
  input  logic [`PUT_BITS-1:0]     free_index_i
);

  localparam int                    c_beat_lg   = $clog2(BEAT_BYTES);
  localparam logic [c_putlists-1:0] c_free_one  = 1;
  localparam logic [c_cnt_bits-1:0] c_cnt_one   = 1;

  state_t                  r_state;
  logic [c_cnt_bits-1:0]   r_cnt;
  logic [c_put_bits-1:0]   r_idx;
  logic [c_putlists-1:0]   r_free;

  logic                    w_is_put;
  logic                    w_any_free;
  logic                    w_put_ok;
  logic                    w_first_put_fire;
  logic                    w_burst_fire;
  logic [c_putlists-1:0]   w_alloc_oh;
  logic [c_put_bits-1:0]   w_alloc_idx;
  logic [c_cnt_bits-1:0]   w_beats_m1;
  logic [c_putlists-1:0]   w_rel_mask;
  logic [c_putlists-1:0]   w_alloc_mask;
  logic [c_putlists-1:0]   w_free_nxt;

  put_free_pe u_pe (
    .free_vec (r_free),
    .any_free (w_any_free),
    .onehot   (w_alloc_oh),
    .index    (w_alloc_idx)
  );

  assign w_is_put   = (a_opcode_i == PUT_OPC_FULL) || (a_opcode_i == PUT_OPC_PART);
  assign w_put_ok   = w_any_free && push_ready_i;
  assign w_beats_m1 = beats_minus1(a_size_i, c_beat_lg);

  assign w_first_put_fire = (r_state == ST_IDLE) && a_valid_i && w_is_put &&
                            w_put_ok && req_ready_i;
  assign w_burst_fire     = (r_state == ST_BURST) && a_valid_i && push_ready_i;

  // Descriptor and data always mirror the A channel; the valids qualify them.
  assign req_opcode_o  = a_opcode_i;
  assign req_size_o    = a_size_i;
  assign req_source_o  = a_source_i;
  assign req_address_o = a_address_i;
  assign req_put_o     = w_is_put ? w_alloc_idx : '0;
  assign push_data_o   = a_data_i;
  assign push_mask_o   = a_mask_i;

  always_comb begin
    a_ready_o    = 1'b0;
    req_valid_o  = 1'b0;
    push_valid_o = 1'b0;
    push_index_o = r_idx;
    case (r_state)
      ST_IDLE: begin
        req_valid_o  = a_valid_i && (!w_is_put || w_put_ok);
        a_ready_o    = a_valid_i && req_ready_i && (!w_is_put || w_put_ok);
        push_valid_o = a_valid_i && w_is_put && w_put_ok && req_ready_i;
        push_index_o = w_alloc_idx;
      end
      ST_BURST: begin
        a_ready_o    = push_ready_i;
        push_valid_o = a_valid_i;
      end
      default: begin
        a_ready_o    = 1'b0;
      end
    endcase
  end

  // Clearing after setting keeps an allocation from being undone by a stray release.
  assign w_rel_mask   = free_valid_i ? (c_free_one << free_index_i) : '0;
  assign w_alloc_mask = w_first_put_fire ? w_alloc_oh : '0;
  assign w_free_nxt   = (r_free | w_rel_mask) & ~w_alloc_mask;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
      r_idx   <= '0;
      r_free  <= '1;
    end else begin
      r_free <= w_free_nxt;
      case (r_state)
        ST_IDLE: begin
          if (w_first_put_fire) begin
            r_idx <= w_alloc_idx;
            if (w_beats_m1 != '0) begin
              r_cnt   <= w_beats_m1;
              r_state <= ST_BURST;
            end
          end
        end
        ST_BURST: begin
          if (w_burst_fire) begin
            r_cnt <= r_cnt - c_cnt_one;
            if (r_cnt == c_cnt_one) r_state <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: doc/sink_a_put_alloc.md
SINK_A_PUT_ALLOC -- requirements
Module: sink_a_put_alloc

Interface
REQ-001 SHALL have parameter BEAT_BYTES, default `DATA_BITS/8, bytes per A-channel data beat.
REQ-002 SHALL have parameter PUT_OPC_FULL, default 3'd0, PutFullData opcode.
REQ-003 SHALL have parameter PUT_OPC_PART, default 3'd1, PutPartialData opcode.
REQ-004 SHALL have ports clk in 1 clock; rst_n in 1 reset, asynchronous, active-low.
REQ-005 SHALL have ports a_valid_i in 1, a_ready_o out 1: A-channel beat handshake.
REQ-006 SHALL have ports a_opcode_i in `OP_BITS, a_size_i in `SIZE_BITS (log2 bytes), a_source_i in `SOURCE_BITS, a_address_i in `ADDRESS_BITS, a_data_i in `DATA_BITS, a_mask_i in `MASK_BITS.
REQ-007 SHALL have ports push_valid_o out 1, push_ready_i in 1, push_index_o out `PUT_BITS, push_data_o out `DATA_BITS, push_mask_o out `MASK_BITS: list-buffer push side.
REQ-008 SHALL have ports req_valid_o out 1, req_ready_i in 1, req_opcode_o out `OP_BITS, req_size_o out `SIZE_BITS, req_source_o out `SOURCE_BITS, req_address_o out `ADDRESS_BITS, req_put_o out `PUT_BITS: request descriptor.
REQ-009 SHALL have ports free_valid_i in 1, free_index_i in `PUT_BITS: put-list release from the consumer.

Function
REQ-010 SHALL classify a beat as Put when a_opcode_i is PUT_OPC_FULL or PUT_OPC_PART; all other opcodes are request-only (no push, no allocation).
REQ-011 SHALL keep a `PUTLISTS-bit free vector, reset all ones; allocation picks the lowest-indexed set bit.
REQ-012 SHALL implement FSM IDLE/BURST; reset state IDLE.
REQ-013 In IDLE, req_valid_o = a_valid_i && (!Put || (free!=0 && push_ready_i)), descriptor fields driven combinationally from A inputs, req_put_o = allocated index (0 for non-Put).
REQ-014 In IDLE, a_ready_o = req_ready_i && (!Put || (free!=0 && push_ready_i)); push_valid_o = a_valid_i && Put && free!=0 && req_ready_i.
REQ-015 First-beat Put acceptance SHALL clear the allocated free bit, latch the index, and push data/mask to that index in the same cycle (zero latency).
REQ-016 Beat count SHALL be max(1, 2^a_size_i / BEAT_BYTES); if >1, load counter = count-1 and enter BURST, else stay IDLE.
REQ-017 In BURST, req_valid_o = 0, a_ready_o = push_ready_i, push_valid_o = a_valid_i, push_index_o = latched index; each accepted beat decrements the counter; beat with counter==1 returns to IDLE.
REQ-018 a_opcode_i/a_size_i during BURST SHALL be ignored (burst length fixed at first beat).
REQ-019 free_valid_i SHALL set free[free_index_i] next cycle; release of an already-free index has no effect.
REQ-020 Same-cycle allocation and release of different indices SHALL both take effect; a released index becomes allocatable the cycle after release.
REQ-021 With free==0 or push_ready_i low, a first-beat Put SHALL stall (a_ready_o=0, req_valid_o=0, push_valid_o=0) with no state change.
REQ-022 No output SHALL depend combinationally on free_valid_i.

Reset
REQ-023 On rst_n low: state IDLE, counter 0, latched index 0, free vector all ones; outputs a_ready_o, push_valid_o, req_valid_o SHALL be 0 while a_valid_i is 0.
REQ-024 Reset mid-burst SHALL abandon the burst; the next beat after reset is treated as a first beat.

Structure
REQ-025 `PUT_BITS, `PUTLISTS, `DATA_BITS, `MASK_BITS, `SOURCE_BITS, `OP_BITS, `SIZE_BITS, `ADDRESS_BITS SHALL come from shared define.v; opcode constants also belong there.
REQ-026 Lowest-set-bit selection SHALL use a priority-encoder sub-module, put_free_pe, (one-hot then existing one2bin).

Verification
REQ-027 Single-beat PutFull, size=log2(BEAT_BYTES), all free -> same cycle req_valid_o=1, req_put_o=0, push_index_o=0; free[0] clears.
REQ-028 Four-beat PutPartial (size=log2(4*BEAT_BYTES)) -> one request, four pushes all to index 0, FSM back to IDLE after beat 4.
REQ-029 Get (opcode 4) -> request only, push_valid_o=0, free vector unchanged.
REQ-030 Allocate all `PUTLISTS indices, present Put -> a_ready_o=0; free_valid_i with index 2 -> next cycle Put accepted with req_put_o=2.
REQ-031 push_ready_i low on beat 2 of burst -> a_ready_o=0, counter held, resumes on push_ready_i high.
REQ-032 rst_n asserted after beat 2 of a 4-beat burst -> FSM IDLE, free all ones; next beat issues a new request.
